// File: rtl/ln_pkg.sv
// ln_pkg
// Shared definitions for the ln streaming responder: fixed-point constants,
// IEEE-754 single-precision field layout, the Q16.16 result type and the
// ln(1+f) table geometry.
// Ports: none (package).
package ln_pkg;

   // ln(1+f) segmentation: 2^SEGS_LOG2 equal segments over f in [0,1)
   localparam int SEGS_LOG2 = 5;

   // ln(2) in Q16.16, and the result code reported for invalid operands
   localparam logic [31:0] LN2_Q16  = 32'h0000B172;
   localparam logic [31:0] ERR_CODE = 32'h80000000;

   // IEEE-754 single-precision field layout
   localparam int FP_SIGN_BIT = 31;
   localparam int FP_EXP_LSB  = 23;
   localparam int FP_EXP_W    = 8;
   localparam int FP_MAN_W    = 23;
   localparam int FP_EXP_BIAS = 127;

   // Mantissa bits left over after the segment index
   localparam int RES_W = FP_MAN_W - SEGS_LOG2;

   typedef logic signed [31:0] q16_16_t;
   typedef logic [15:0]        seg_coef_t;

endpackage

// File: rtl/ln1p_seg_rom.sv
// ln1p_seg_rom
// Combinational 32-entry table for piecewise-linear ln(1+f).
// For segment idx (f in [idx/32, (idx+1)/32)):
//   c = round(ln(1 + idx/32) * 65536)                       intercept
//   m = round((ln(1+(idx+1)/32) - ln(1+idx/32)) * 65536)    rise across segment
// Ports:
//   idx  in   SEGS_LOG2  segment index (top mantissa bits)
//   c    out  16         unsigned intercept, Q0.16
//   m    out  16         unsigned segment rise, Q0.16
module ln1p_seg_rom
   import ln_pkg::*;
(
   input  logic [SEGS_LOG2-1:0] idx,
   output seg_coef_t            c,
   output seg_coef_t            m
);

   always_comb begin
      c = '0;
      m = '0;
      case (idx)
         5'd0:  begin c = 16'd0;     m = 16'd2017; end
         5'd1:  begin c = 16'd2017;  m = 16'd1956; end
         5'd2:  begin c = 16'd3973;  m = 16'd1900; end
         5'd3:  begin c = 16'd5873;  m = 16'd1846; end
         5'd4:  begin c = 16'd7719;  m = 16'd1796; end
         5'd5:  begin c = 16'd9515;  m = 16'd1748; end
         5'd6:  begin c = 16'd11262; m = 16'd1702; end
         5'd7:  begin c = 16'd12965; m = 16'd1659; end
         5'd8:  begin c = 16'd14624; m = 16'd1618; end
         5'd9:  begin c = 16'd16242; m = 16'd1579; end
         5'd10: begin c = 16'd17821; m = 16'd1542; end
         5'd11: begin c = 16'd19364; m = 16'd1507; end
         5'd12: begin c = 16'd20870; m = 16'd1473; end
         5'd13: begin c = 16'd22343; m = 16'd1440; end
         5'd14: begin c = 16'd23783; m = 16'd1409; end
         5'd15: begin c = 16'd25193; m = 16'd1380; end
         5'd16: begin c = 16'd26573; m = 16'd1351; end
         5'd17: begin c = 16'd27924; m = 16'd1324; end
         5'd18: begin c = 16'd29248; m = 16'd1298; end
         5'd19: begin c = 16'd30546; m = 16'd1273; end
         5'd20: begin c = 16'd31818; m = 16'd1248; end
         5'd21: begin c = 16'd33067; m = 16'd1225; end
         5'd22: begin c = 16'd34292; m = 16'd1203; end
         5'd23: begin c = 16'd35494; m = 16'd1181; end
         5'd24: begin c = 16'd36675; m = 16'd1160; end
         5'd25: begin c = 16'd37835; m = 16'd1140; end
         5'd26: begin c = 16'd38975; m = 16'd1120; end
         5'd27: begin c = 16'd40095; m = 16'd1101; end
         5'd28: begin c = 16'd41196; m = 16'd1083; end
         5'd29: begin c = 16'd42280; m = 16'd1066; end
         5'd30: begin c = 16'd43345; m = 16'd1049; end
         5'd31: begin c = 16'd44394; m = 16'd1032; end
         default: begin c = '0; m = '0; end
      endcase
   end

endmodule

// File: rtl/ln_stream_responder.sv
// ln_stream_responder
// Streaming natural log: one IEEE-754 single x accepted per clock while
// start_export is high, signed Q16.16 ln(x) returned in order LATENCY edges
// after capture. ln(x) = (e-127)*ln2 + ln(1+f), with ln(1+f) interpolated
// linearly inside 32 table segments.
// Pipeline: capture register, then classify, lookup, interpolate, sum.
// Ports:
//   clk_clk        in   1   clock, all state on the rising edge
//   reset_reset    in   1   synchronous active-high reset
//   start_export   in   1   x_export valid and consumed this cycle
//   x_export       in   32  IEEE-754 single-precision operand
//   ln_export      out  32  signed Q16.16 result (valid when done)
//   status_export  out  2   [1] done, [0] error (operand invalid)
module ln_stream_responder
   import ln_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int SEGS_LOG2 = 5
)(
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        start_export,
   input  logic [31:0] x_export,
   output logic [31:0] ln_export,
   output logic [1:0]  status_export
);

   // The stage structure below is fixed; reject any other configuration
   generate
      if (LATENCY != 4 || SEGS_LOG2 != ln_pkg::SEGS_LOG2) begin : g_bad_cfg
         $error("ln_stream_responder: only LATENCY=4 and SEGS_LOG2=5 are supported");
      end
   endgenerate

   // vld[0] = capture register, vld[4] = stage 4 (done)
   logic [4:0]          vld;

   logic [31:0]         cap_x;

   logic                err1;
   logic signed [8:0]   eu1;
   logic [FP_MAN_W-1:0] f1;

   logic                err2;
   q16_16_t             eln2_2;
   seg_coef_t           c2;
   seg_coef_t           m2;
   logic [RES_W-1:0]    r2;

   logic                err3;
   q16_16_t             eln2_3;
   logic [16:0]         lf3;

   q16_16_t             ln_q;
   logic                err_q;

   logic [FP_EXP_W-1:0] cap_exp;
   logic                err_c;
   logic signed [8:0]   eu_c;
   q16_16_t             eln2_c;
   seg_coef_t           rom_c;
   seg_coef_t           rom_m;
   logic [33:0]         prod_c;
   logic [16:0]         lf_c;

   ln1p_seg_rom u_rom (
      .idx (f1[FP_MAN_W-1 -: ln_pkg::SEGS_LOG2]),
      .c   (rom_c),
      .m   (rom_m)
   );

   // Stage-local arithmetic. Zero/denormal, inf/NaN and negative operands
   // are flagged; their data still flows but is overridden at stage 4.
   // eu*ln2 stays below 2^23 in magnitude so 32-bit signed math is safe.
   always_comb begin
      cap_exp = cap_x[FP_EXP_LSB +: FP_EXP_W];
      err_c   = cap_x[FP_SIGN_BIT] | (cap_exp == '0) | (cap_exp == '1);
      eu_c    = $signed({1'b0, cap_exp}) - 9'sd127;
      eln2_c  = $signed({{23{eu1[8]}}, eu1}) * $signed(LN2_Q16);
      prod_c  = {18'b0, m2} * {16'b0, r2};
      lf_c    = {1'b0, c2} + {1'b0, prod_c[33:RES_W]};
   end

   // Valid shift register and output register. Outputs only change when a
   // valid item arrives, so they hold through bubbles; reset wipes every
   // in-flight item and wins over a simultaneous start.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         vld   <= '0;
         ln_q  <= '0;
         err_q <= 1'b0;
      end else begin
         vld <= {vld[3:0], start_export};
         if (vld[3]) begin
            ln_q  <= err3 ? q16_16_t'(ERR_CODE) : (eln2_3 + $signed({15'b0, lf3}));
            err_q <= err3;
         end
      end
   end

   // Data pipeline. These registers are qualified by vld and need no reset.
   always_ff @(posedge clk_clk) begin
      cap_x  <= x_export;

      err1   <= err_c;
      eu1    <= eu_c;
      f1     <= cap_x[FP_MAN_W-1:0];

      err2   <= err1;
      eln2_2 <= eln2_c;
      c2     <= rom_c;
      m2     <= rom_m;
      r2     <= f1[RES_W-1:0];

      err3   <= err2;
      eln2_3 <= eln2_2;
      lf3    <= lf_c;
   end

   assign ln_export     = ln_q;
   assign status_export = {vld[4], err_q};

endmodule

// File: tb/tb_ln_stream_responder.sv
// tb_ln_stream_responder
// Directed and random stimulus for ln_stream_responder. Each accepted operand
// pushes its expected result and due cycle into a scoreboard; a negedge
// monitor checks done timing every cycle and pops/compares values.
module tb_ln_stream_responder;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        start_export;
   logic [31:0] x_export;
   logic [31:0] ln_export;
   logic [1:0]  status_export;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] ln;
      int          tol;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   edge_count = 0;
   bit   mon_on = 1'b0;

   localparam logic [31:0] ERR_WORD = 32'h80000000;

   ln_stream_responder dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .start_export  (start_export),
      .x_export      (x_export),
      .ln_export     (ln_export),
      .status_export (status_export)
   );

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) edge_count <= edge_count + 1;

   // Real-valued reference for positive normal operands
   function automatic int ref_ln(input logic [31:0] x);
      real lnv;
      int  e;
      e   = int'(x[30:23]);
      lnv = real'(e - 127) * 0.6931471805599453 + $ln(1.0 + real'(x[22:0]) / 8388608.0);
      return int'(lnv * 65536.0);
   endfunction

   // Drive one cycle of inputs just after a rising edge. An accepted
   // operand is due on the negedge after capture edge + 4. Reset discards
   // everything still queued. tol < 0 selects the real-valued reference.
   task automatic apply_stimulus(input logic st, input logic [31:0] x, input logic rst,
                                 input logic [31:0] exp_ln, input logic exp_err, input int tol);
      exp_t item;
      @(posedge clk_clk);
      #2;
      reset_reset  = rst;
      start_export = st;
      x_export     = x;
      if (rst) begin
         sb.delete();
      end else if (st) begin
         item.due = edge_count + 5;
         item.err = exp_err;
         if (tol < 0) begin
            item.ln  = ref_ln(x);
            item.tol = 16;
         end else begin
            item.ln  = exp_ln;
            item.tol = tol;
         end
         sb.push_back(item);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
   endtask

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Monitor: done must be high exactly on cycles where the oldest
   // scoreboard entry falls due, and the value must match that entry.
   always @(negedge clk_clk) begin
      exp_t e;
      logic exp_done;
      logic ok;
      int   diff;
      if (mon_on) begin
         exp_done = (sb.size() > 0) && (sb[0].due == edge_count);
         total++;
         assert (status_export[1] === exp_done) else begin
            bad++;
            $error("FAIL done_timing edge=%0d got=%b want=%b", edge_count, status_export[1], exp_done);
         end
         if (exp_done) begin
            e = sb.pop_front();
            if (status_export[1] === 1'b1) begin
               diff = int'($signed(ln_export)) - int'($signed(e.ln));
               if (diff < 0) diff = -diff;
               if (e.err) ok = (status_export[0] === 1'b1) && (ln_export === ERR_WORD);
               else       ok = (status_export[0] === 1'b0) && (diff <= e.tol);
               total++;
               assert (ok) else begin
                  bad++;
                  $error("FAIL result edge=%0d got=%h err=%b want=%h err=%b tol=%0d",
                         edge_count, ln_export, status_export[0], e.ln, e.err, e.tol);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0]  re;
      logic [31:0] rx;

      reset_reset  = 1'b1;
      start_export = 1'b0;
      x_export     = 32'h0;
      $display("[TB] reset");
      repeat (2) @(posedge clk_clk);
      @(negedge clk_clk);
      check_output("rst_done", {31'b0, status_export[1]}, 32'h0);
      check_output("rst_err",  {31'b0, status_export[0]}, 32'h0);
      check_output("rst_ln",   ln_export, 32'h0);
      mon_on = 1'b1;

      // start held across reset: only the post-reset operand is taken
      apply_stimulus(1'b1, 32'h3F800000, 1'b1, 32'h0, 1'b0, 0);
      apply_stimulus(1'b1, 32'h40000000, 1'b0, 32'h0000B172, 1'b0, 1);
      idle(8);

      $display("[TB] single 1.0");
      apply_stimulus(1'b1, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1);
      idle(8);

      $display("[TB] burst 2.0 0.5 1.5");
      apply_stimulus(1'b1, 32'h40000000, 1'b0, 32'h0000B172, 1'b0, 1);
      apply_stimulus(1'b1, 32'h3F000000, 1'b0, 32'hFFFF4E8E, 1'b0, 1);
      apply_stimulus(1'b1, 32'h3FC00000, 1'b0, 32'h000067CD, 1'b0, 1);
      idle(8);

      $display("[TB] invalid operands with valid neighbours");
      apply_stimulus(1'b1, 32'hBF800000, 1'b0, ERR_WORD, 1'b1, 0);
      apply_stimulus(1'b1, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1);
      apply_stimulus(1'b1, 32'h00000000, 1'b0, ERR_WORD, 1'b1, 0);
      apply_stimulus(1'b1, 32'h3FA00000, 1'b0, 32'h00003920, 1'b0, 1);
      apply_stimulus(1'b1, 32'h7F800000, 1'b0, ERR_WORD, 1'b1, 0);
      apply_stimulus(1'b1, 32'h7FC00000, 1'b0, ERR_WORD, 1'b1, 0);
      apply_stimulus(1'b1, 32'h00000001, 1'b0, ERR_WORD, 1'b1, 0);
      apply_stimulus(1'b1, 32'h00800000, 1'b0, 32'(-126 * 45426), 1'b0, 1);
      apply_stimulus(1'b1, 32'h7F7FFFFF, 1'b0, 32'h0, 1'b0, -1);
      apply_stimulus(1'b1, 32'h3FC00000, 1'b0, 32'h000067CD, 1'b0, 1);
      idle(8);

      // Exponent range keeps the ln2 quantisation well inside the tolerance
      $display("[TB] random stream of 140");
      for (int i = 0; i < 140; i++) begin
         re = 8'($urandom_range(157, 97));
         rx = {1'b0, re, 23'($urandom)};
         apply_stimulus(1'b1, rx, 1'b0, 32'h0, 1'b0, -1);
      end
      idle(8);

      $display("[TB] reset with items in flight");
      apply_stimulus(1'b1, 32'h40000000, 1'b0, 32'h0000B172, 1'b0, 1);
      apply_stimulus(1'b1, 32'h3F000000, 1'b0, 32'hFFFF4E8E, 1'b0, 1);
      apply_stimulus(1'b1, 32'h3FC00000, 1'b0, 32'h000067CD, 1'b0, 1);
      apply_stimulus(1'b1, 32'h40000000, 1'b1, 32'h0, 1'b0, 0);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      @(negedge clk_clk);
      check_output("midrst_ln",  ln_export, 32'h0);
      check_output("midrst_err", {31'b0, status_export[0]}, 32'h0);
      idle(8);
      apply_stimulus(1'b1, 32'h40000000, 1'b0, 32'h0000B172, 1'b0, 1);
      apply_stimulus(1'b1, 32'h3F000000, 1'b0, 32'hFFFF4E8E, 1'b0, 1);
      idle(8);

      $display("[TB] gapped pattern 1,0,1,1,0,1");
      apply_stimulus(1'b1, 32'h40400000, 1'b0, 32'h0, 1'b0, -1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      apply_stimulus(1'b1, 32'h41200000, 1'b0, 32'h0, 1'b0, -1);
      apply_stimulus(1'b1, 32'h3E800000, 1'b0, 32'(-2 * 45426), 1'b0, 1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      apply_stimulus(1'b1, 32'h3FA00000, 1'b0, 32'h00003920, 1'b0, 1);
      idle(2);

      for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk_clk);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL drain pending=%0d want=0", sb.size());
      end
      idle(2);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
